// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard and MDU sequencing control.
//
// Detects load-use and multiply/divide-unit hazards for the instruction in D,
// tracks the MDU latency countdown, and sequences the exception flush.
//
// Parameters:
//   MULT_CYC  multiply latency in cycles (2..15)
//   DIV_CYC   divide latency in cycles (2..15)
//
// Ports:
//   clk                    single clock, rising-edge state updates
//   reset                  synchronous active-low reset
//   rs_D, rt_D             source registers of the D instruction
//   use_rs_D, use_rt_D     D instruction reads rs / rt
//   md_use_D               D instruction touches the MDU (mult/div/mfhi/mflo/mthi/mtlo)
//   ld_E                   E instruction is a load
//   wa_E                   destination register of the E instruction
//   md_start_E, md_div_E   E starts an MDU op this cycle; 1 = divide, 0 = multiply
//   exc_M                  M instruction raises an exception or eret
//   stall_F, stall_D       hold PC and F/D register
//   clr_D..clr_W           clear F/D, D/E, E/M, M/W registers
//   md_busy                MDU operation in progress
//   md_cnt                 remaining MDU cycles
//   stall_cnt              (HAZARD_STATS_EN only) saturating count of stall_F cycles
//
// Optional feature: define HAZARD_STATS_EN to add the stall_cnt output.

module hazard_ctrl #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic       use_rs_D,
  input  logic       use_rt_D,
  input  logic       md_use_D,
  input  logic       ld_E,
  input  logic [4:0] wa_E,
  input  logic       md_start_E,
  input  logic       md_div_E,
  input  logic       exc_M,
  output logic       stall_F,
  output logic       stall_D,
  output logic       clr_D,
  output logic       clr_E,
  output logic       clr_M,
  output logic       clr_W,
  output logic       md_busy,
  output logic [3:0] md_cnt
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN,
    MDU,
    FLUSH
  } state_t;

  state_t     state, state_n;
  logic [3:0] md_cnt_n;
  logic       load_use;
  logic       md_hazard;

  // Register 0 is never a real dependency, so wa_E==0 suppresses the stall.
  assign load_use  = ld_E && (wa_E != 5'd0) &&
                     ((use_rs_D && (rs_D == wa_E)) || (use_rt_D && (rt_D == wa_E)));
  assign md_hazard = md_use_D && ((state == MDU) || md_start_E);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= RUN;
      md_cnt <= '0;
    end else begin
      state  <= state_n;
      md_cnt <= md_cnt_n;
    end
  end

  always_comb begin
    state_n  = state;
    md_cnt_n = md_cnt;
    case (state)
      RUN: begin
        if (md_start_E) begin
          state_n  = MDU;
          md_cnt_n = md_div_E ? 4'(DIV_CYC) : 4'(MULT_CYC);
        end
      end
      MDU: begin
        // md_start_E is ignored here; correct stalling prevents it.
        if (md_cnt <= 4'd1) begin
          state_n  = RUN;
          md_cnt_n = '0;
        end else begin
          md_cnt_n = md_cnt - 4'd1;
        end
      end
      FLUSH: begin
        state_n = RUN;
      end
      default: begin
        state_n  = RUN;
        md_cnt_n = '0;
      end
    endcase
    // Exception overrides everything, aborting any MDU operation.
    if (exc_M) begin
      state_n  = FLUSH;
      md_cnt_n = '0;
    end
  end

  always_comb begin
    stall_F = 1'b0;
    stall_D = 1'b0;
    clr_D   = 1'b0;
    clr_E   = 1'b0;
    clr_M   = 1'b0;
    clr_W   = 1'b0;
    md_busy = 1'b0;
    if (!reset || exc_M) begin
      clr_D = 1'b1;
      clr_E = 1'b1;
      clr_M = 1'b1;
      clr_W = 1'b1;
      md_busy = reset && (state == MDU);
    end else begin
      md_busy = (state == MDU);
      if (state == FLUSH) begin
        clr_D = 1'b1;
      end else if (load_use || md_hazard) begin
        stall_F = 1'b1;
        stall_D = 1'b1;
        clr_E   = 1'b1;
      end
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (stall_F && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl -- self-checking bench for hazard_ctrl.
// Directed scenarios followed by randomized traffic, all checked against a
// behavioural model that tracks only "cycles of MDU work left" and a
// pending-flush flag.

module tb_hazard_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs_D, rt_D, wa_E;
  logic       use_rs_D, use_rt_D, md_use_D, ld_E, md_start_E, md_div_E, exc_M;
  logic       stall_F, stall_D, clr_D, clr_E, clr_M, clr_W, md_busy;
  logic [3:0] md_cnt;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  hazard_ctrl #(.MULT_CYC(MC), .DIV_CYC(DC)) dut (
    .clk(clk), .reset(reset),
    .rs_D(rs_D), .rt_D(rt_D), .use_rs_D(use_rs_D), .use_rt_D(use_rt_D),
    .md_use_D(md_use_D), .ld_E(ld_E), .wa_E(wa_E),
    .md_start_E(md_start_E), .md_div_E(md_div_E), .exc_M(exc_M),
    .stall_F(stall_F), .stall_D(stall_D),
    .clr_D(clr_D), .clr_E(clr_E), .clr_M(clr_M), .clr_W(clr_W),
    .md_busy(md_busy), .md_cnt(md_cnt)
`ifdef HAZARD_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model state: MDU work remaining and whether the flush cycle is next.
  int          m_left  = 0;
  bit          m_flush = 0;
  longint      m_stalls = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic idle();
    reset = 1'b1; rs_D = '0; rt_D = '0; wa_E = '0;
    use_rs_D = 0; use_rt_D = 0; md_use_D = 0; ld_E = 0;
    md_start_E = 0; md_div_E = 0; exc_M = 0;
  endtask

  // Check outputs for the current inputs, advance the model, move to next negedge.
  task automatic tick();
    bit lu, hz, e_stall, e_cD, e_cE, e_cMW, e_busy;
    #1;
    lu = ld_E && (wa_E != 0) &&
         ((use_rs_D && rs_D == wa_E) || (use_rt_D && rt_D == wa_E));
    hz = lu || (md_use_D && (m_left > 0 || md_start_E));
    e_stall = 0; e_cD = 0; e_cE = 0; e_cMW = 0; e_busy = 0;
    if (!reset || exc_M) begin
      e_cD = 1; e_cE = 1; e_cMW = 1;
      e_busy = reset && (m_left > 0);
    end else begin
      e_busy = (m_left > 0);
      if (m_flush) e_cD = 1;
      else if (hz) begin e_stall = 1; e_cE = 1; end
    end
    check("stall_F", 32'(stall_F), 32'(e_stall));
    check("stall_D", 32'(stall_D), 32'(e_stall));
    check("clr_D",   32'(clr_D),   32'(e_cD));
    check("clr_E",   32'(clr_E),   32'(e_cE));
    check("clr_M",   32'(clr_M),   32'(e_cMW));
    check("clr_W",   32'(clr_W),   32'(e_cMW));
    check("md_busy", 32'(md_busy), 32'(e_busy));
    check("md_cnt",  32'(md_cnt),  32'(m_left));
`ifdef HAZARD_STATS_EN
    check("stall_cnt", stall_cnt, 32'(m_stalls));
`endif
    if (!reset) begin
      m_left = 0; m_flush = 0; m_stalls = 0;
    end else begin
      if (e_stall && m_stalls < 64'hFFFF_FFFF) m_stalls++;
      if (exc_M) begin
        m_left = 0; m_flush = 1;
      end else if (m_flush) begin
        m_flush = 0;
      end else if (m_left > 0) begin
        m_left--;
      end else if (md_start_E) begin
        m_left = md_div_E ? DC : MC;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    idle();
    reset = 1'b0;
    @(negedge clk);
    // Reset with noisy inputs must still force the reset response.
    exc_M = 1; md_start_E = 1; ld_E = 1; wa_E = 5'd3; rs_D = 5'd3; use_rs_D = 1;
    tick();
    tick();

    // Load-use hazard, then the same with register 0.
    idle(); ld_E = 1; wa_E = 5'd8; rs_D = 5'd8; use_rs_D = 1;
    tick();
    wa_E = 5'd0; rs_D = 5'd0;
    tick();

    // Multiply with a dependent mfhi held in D throughout.
    idle(); md_start_E = 1; md_use_D = 1;
    tick();
    md_start_E = 0;
    for (int i = 0; i < MC + 1; i++) tick();
    idle(); tick();

    // Divide aborted by an exception at md_cnt == 6.
    md_start_E = 1; md_div_E = 1;
    tick();
    idle();
    for (int i = 0; i < 20 && m_left != 6; i++) tick();
    check("div_cnt_at_6", 32'(md_cnt), 32'd6);
    exc_M = 1; tick();
    idle(); tick(); tick();

    // Exception, MDU start and load-use all at once.
    exc_M = 1; md_start_E = 1; ld_E = 1; wa_E = 5'd4; rt_D = 5'd4; use_rt_D = 1; md_use_D = 1;
    tick();
    idle(); tick(); tick();

    // Reset arriving mid-multiply at md_cnt == 3.
    md_start_E = 1; tick();
    idle();
    for (int i = 0; i < 20 && m_left != 3; i++) tick();
    reset = 0; tick(); tick();
    idle(); tick();

`ifdef HAZARD_STATS_EN
    // One multiply-blocked mfhi after reset.
    md_start_E = 1; tick();
    idle(); md_use_D = 1;
    for (int i = 0; i < MC; i++) tick();
    idle(); tick();
`endif

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 59) != 0);
      rs_D       = 5'($urandom_range(0, 3));
      rt_D       = 5'($urandom_range(0, 3));
      wa_E       = 5'($urandom_range(0, 3));
      use_rs_D   = 1'($urandom);
      use_rt_D   = 1'($urandom);
      ld_E       = ($urandom_range(0, 2) == 0);
      md_use_D   = ($urandom_range(0, 2) == 0);
      md_start_E = ($urandom_range(0, 5) == 0);
      md_div_E   = 1'($urandom);
      exc_M      = ($urandom_range(0, 19) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MULT_CYC, default 5: multiply latency in cycles, range 2..15.
REQ-002 Parameter DIV_CYC, default 10: divide latency in cycles, range 2..15.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
REQ-005 rs_D, rt_D  in  5 each  source register numbers of the instruction in D.
REQ-006 use_rs_D, use_rt_D  in  1 each  D instruction reads rs / rt.
REQ-007 md_use_D  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-008 ld_E  in  1  E instruction is a load (MEM_TO_REG selects memory).
REQ-009 wa_E  in  5  destination register of the E instruction.
REQ-010 md_start_E  in  1  E instruction starts an MDU operation this cycle.
REQ-011 md_div_E  in  1  with md_start_E: 1 = divide, 0 = multiply.
REQ-012 exc_M  in  1  M instruction raises an exception or eret this cycle.
REQ-013 stall_F, stall_D  out  1 each  hold PC and F/D register.
REQ-014 clr_D, clr_E, clr_M, clr_W  out  1 each  clear F/D, D/E, E/M, M/W registers.
REQ-015 md_busy  out  1  MDU operation in progress.
REQ-016 md_cnt  out  4  remaining MDU cycles.

Function
REQ-017 FSM states SHALL be RUN, MDU, FLUSH; stall/clr outputs are combinational from state and inputs; state and md_cnt are registered.
REQ-018 Load-use hazard SHALL be ld_E & wa_E!=0 & ((use_rs_D & rs_D==wa_E) | (use_rt_D & rt_D==wa_E)).
REQ-019 MDU hazard SHALL be md_use_D & (state==MDU | md_start_E).
REQ-020 Any hazard, without exc_M, SHALL assert stall_F=stall_D=clr_E=1 in the same cycle; clr_D=clr_M=clr_W=0.
REQ-021 RUN & md_start_E & !exc_M: md_cnt loads DIV_CYC if md_div_E else MULT_CYC; next state MDU.
REQ-022 In MDU: md_cnt decrements by 1 per cycle; at md_cnt==1, next md_cnt=0 and next state RUN; md_busy = (state==MDU).
REQ-023 md_start_E while in MDU SHALL be ignored (cannot occur after correct stalling).
REQ-024 exc_M SHALL have top priority: clr_D=clr_E=clr_M=clr_W=1, stall_F=stall_D=0; next state FLUSH; md_cnt cleared to 0 (MDU aborted); md_start_E in that cycle ignored.
REQ-025 FLUSH SHALL last exactly one cycle, assert clr_D=1 only, then go to RUN; hazards are not evaluated in FLUSH.
REQ-026 With no hazard and no exception, all stall/clr outputs SHALL be 0.
REQ-027 rs_D/rt_D/wa_E equal to 0 SHALL never produce a load-use stall.

Reset
REQ-028 While reset==0 at a clock edge: state<=RUN, md_cnt<=0.
REQ-029 While reset==0: clr_D=clr_E=clr_M=clr_W=1, stall_F=stall_D=0, md_busy=0, overriding all inputs; reset mid-MDU SHALL abort the operation.

Configuration
REQ-030 Macro HAZARD_STATS_EN SHALL, when defined, add output stall_cnt (32 bits), incremented in every cycle with stall_F=1, saturating at 0xFFFFFFFF, cleared by reset.
REQ-031 Without HAZARD_STATS_EN, port stall_cnt and its counter SHALL not exist; all other behaviour identical.

Verification
REQ-032 ld_E=1, wa_E=8, rs_D=8, use_rs_D=1 -> stall_F=stall_D=clr_E=1 same cycle; with wa_E=0 -> all 0.
REQ-033 md_start_E=1, md_div_E=0 at cycle t -> md_busy=1 cycles t+1..t+5, md_cnt 5,4,3,2,1, RUN at t+6; md_use_D=1 throughout -> stalled through t+5, released t+6.
REQ-034 Divide started, exc_M=1 at md_cnt=6 -> all four clr=1 that cycle, next cycle FLUSH (clr_D only, md_cnt=0, md_busy=0), then RUN.
REQ-035 exc_M, md_start_E and load-use hazard together -> exception response only, no MDU start, stall_F=0.
REQ-036 reset=0 during MDU at md_cnt=3 -> next edge md_cnt=0, md_busy=0, clr_*=1 while reset low; with HAZARD_STATS_EN, stall_cnt=0 after reset and counts 5 for one multiply-blocked mfhi.
